// File: rtl/minterm_sweep_if.sv
// Handshake bundle between the minterm sweep sequencer and whatever drives it.
// master: control side (start/loop/hold in, select/status out).
// slave : the sequencer itself.
interface minterm_sweep_if;
  logic       start;
  logic       loop;
  logic       hold;
  logic       a;
  logic       b;
  logic       c;
  logic [2:0] step_idx;
  logic       valid;
  logic       busy;
  logic       done;

  modport master (
    output start, loop, hold,
    input  a, b, c, step_idx, valid, busy, done
  );

  modport slave (
    input  start, loop, hold,
    output a, b, c, step_idx, valid, busy, done
  );
endinterface

// File: rtl/minterm_sweep_gen.sv
// Minterm sweep sequencer: walks the a/b/c selects of the downstream 3-to-8
// decoder through all eight codes, each held for DWELL cycles.
// Build option: define SWEEP_GRAY_EN to emit the codes in Gray order
// (one select bit toggles per step); otherwise codes follow step_idx in binary.
//
// state  | meaning
// S_IDLE | selects parked at 000, waiting for start
// S_RUN  | sweeping; code(step_idx) on a/b/c, dwell counter running
// S_DONE | one-cycle completion pulse, then back to idle
module minterm_sweep_gen #(
  parameter int DWELL = 100,
  parameter int CNT_W = 7
) (
  input logic               clk,
  input logic               rst,
  minterm_sweep_if.slave    sif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // DWELL may equal 2^CNT_W, so the terminal count is DWELL-1 truncated to CNT_W.
  localparam logic [CNT_W-1:0] C_TC = CNT_W'(DWELL - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [2:0]       r_idx;
  logic [2:0]       w_idx_nxt;
  logic [2:0]       r_abc;
  logic             r_valid;
  logic             r_busy;
  logic             r_done;

  function automatic logic [2:0] f_code(input logic [2:0] i_idx);
`ifdef SWEEP_GRAY_EN
    return i_idx ^ {1'b0, i_idx[2:1]};
`else
    return i_idx;
`endif
  endfunction

  // State, dwell counter and step index registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= 3'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  // Next-state logic: dwell timing, step advance, wrap or finish.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        w_idx_nxt = 3'd0;
        if (sif.start) begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (!sif.hold) begin
          if (r_cnt == C_TC) begin
            w_cnt_nxt = '0;
            if (r_idx != 3'd7) begin
              w_idx_nxt = r_idx + 3'd1;
            end else begin
              w_idx_nxt = 3'd0;
              if (!sif.loop) begin
                w_state_nxt = S_DONE;
              end
            end
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end
      S_DONE: begin
        w_cnt_nxt   = '0;
        w_idx_nxt   = 3'd0;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_cnt_nxt   = '0;
        w_idx_nxt   = 3'd0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Outputs are registered from the next-state values so they line up with
  // the state they describe without any input-to-output combinational path.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_abc   <= 3'b000;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_abc   <= (w_state_nxt == S_RUN) ? f_code(w_idx_nxt) : 3'b000;
      r_valid <= (w_state_nxt == S_RUN);
      r_busy  <= (w_state_nxt == S_RUN);
      r_done  <= (w_state_nxt == S_DONE);
    end
  end

  assign sif.a        = r_abc[2];
  assign sif.b        = r_abc[1];
  assign sif.c        = r_abc[0];
  assign sif.step_idx = r_idx;
  assign sif.valid    = r_valid;
  assign sif.busy     = r_busy;
  assign sif.done     = r_done;

endmodule

// File: tb/tb_minterm_sweep_gen.sv
// Directed bench for minterm_sweep_gen: a DWELL=4 instance for timing
// scenarios and a DWELL=1 instance for the back-to-back code sequence.
// Observed vector layout: {valid, busy, done, step_idx[2:0], a, b, c}.
module tb_minterm_sweep_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  minterm_sweep_if sif4 ();
  minterm_sweep_if sif1 ();

  minterm_sweep_gen #(.DWELL(4), .CNT_W(7)) u_dut4 (
    .clk (clk),
    .rst (rst),
    .sif (sif4.slave)
  );

  minterm_sweep_gen #(.DWELL(1), .CNT_W(7)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .sif (sif1.slave)
  );

  function automatic logic [2:0] exp_code(input int i);
    logic [2:0] tbl [8];
`ifdef SWEEP_GRAY_EN
    tbl = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100};
`else
    tbl = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b101, 3'b110, 3'b111};
`endif
    return tbl[i];
  endfunction

  task automatic test_reset();
    logic [8:0] obs;
    rst = 1'b1;
    sif4.start = 1'b1; sif4.loop = 1'b1; sif4.hold = 1'b1;
    sif1.start = 1'b1; sif1.loop = 1'b0; sif1.hold = 1'b0;
    repeat (2) @(negedge clk);
    obs = {sif4.valid, sif4.busy, sif4.done, sif4.step_idx, sif4.a, sif4.b, sif4.c};
    checks++;
    if (obs !== 9'b0) begin
      errors++; $display("FAIL reset_dut4 got=%b want=%b", obs, 9'b0);
    end
    obs = {sif1.valid, sif1.busy, sif1.done, sif1.step_idx, sif1.a, sif1.b, sif1.c};
    checks++;
    if (obs !== 9'b0) begin
      errors++; $display("FAIL reset_dut1 got=%b want=%b", obs, 9'b0);
    end
    rst = 1'b0;
    sif4.start = 1'b0; sif4.loop = 1'b0; sif4.hold = 1'b0;
    sif1.start = 1'b0;
    @(negedge clk);
    obs = {sif4.valid, sif4.busy, sif4.done, sif4.step_idx, sif4.a, sif4.b, sif4.c};
    checks++;
    if (obs !== 9'b0) begin
      errors++; $display("FAIL reset_release_idle got=%b want=%b", obs, 9'b0);
    end
  endtask

  task automatic test_full_sweep();
    logic [8:0] obs, exp;
    sif4.start = 1'b1;
    @(negedge clk);
    sif4.start = 1'b0;
    for (int k = 0; k < 32; k++) begin
      exp = {3'b110, 3'(k / 4), exp_code(k / 4)};
      obs = {sif4.valid, sif4.busy, sif4.done, sif4.step_idx, sif4.a, sif4.b, sif4.c};
      checks++;
      if (obs !== exp) begin
        errors++; $display("FAIL sweep_cycle%0d got=%b want=%b", k, obs, exp);
      end
      @(negedge clk);
    end
    obs = {sif4.valid, sif4.busy, sif4.done, sif4.step_idx, sif4.a, sif4.b, sif4.c};
    checks++;
    if (obs !== 9'b001_000_000) begin
      errors++; $display("FAIL sweep_done got=%b want=%b", obs, 9'b001_000_000);
    end
    @(negedge clk);
    obs = {sif4.valid, sif4.busy, sif4.done, sif4.step_idx, sif4.a, sif4.b, sif4.c};
    checks++;
    if (obs !== 9'b0) begin
      errors++; $display("FAIL sweep_idle_after got=%b want=%b", obs, 9'b0);
    end
  endtask

  // Hold sampled at the ends of cycles 11..13; cycle 11 is the terminal count
  // of step 2, so the step is blocked and step 2 spans cycles 8..14.
  task automatic test_hold();
    logic [8:0] obs, exp;
    int         s;
    sif4.start = 1'b1;
    @(negedge clk);
    sif4.start = 1'b0;
    for (int k = 0; k < 35; k++) begin
      sif4.hold = (k >= 11 && k <= 13);
      if (k < 8)       s = k / 4;
      else if (k < 15) s = 2;
      else             s = 3 + (k - 15) / 4;
      exp = {3'b110, 3'(s), exp_code(s)};
      obs = {sif4.valid, sif4.busy, sif4.done, sif4.step_idx, sif4.a, sif4.b, sif4.c};
      checks++;
      if (obs !== exp) begin
        errors++; $display("FAIL hold_cycle%0d got=%b want=%b", k, obs, exp);
      end
      @(negedge clk);
    end
    sif4.hold = 1'b0;
    obs = {sif4.valid, sif4.busy, sif4.done, sif4.step_idx, sif4.a, sif4.b, sif4.c};
    checks++;
    if (obs !== 9'b001_000_000) begin
      errors++; $display("FAIL hold_done got=%b want=%b", obs, 9'b001_000_000);
    end
    @(negedge clk);
  endtask

  // loop held through the first wrap, dropped mid second sweep.
  task automatic test_loop();
    logic [8:0] obs, exp;
    sif4.loop  = 1'b1;
    sif4.start = 1'b1;
    @(negedge clk);
    sif4.start = 1'b0;
    for (int k = 0; k < 64; k++) begin
      if (k == 40) sif4.loop = 1'b0;
      exp = {3'b110, 3'((k / 4) % 8), exp_code((k / 4) % 8)};
      obs = {sif4.valid, sif4.busy, sif4.done, sif4.step_idx, sif4.a, sif4.b, sif4.c};
      checks++;
      if (obs !== exp) begin
        errors++; $display("FAIL loop_cycle%0d got=%b want=%b", k, obs, exp);
      end
      @(negedge clk);
    end
    obs = {sif4.valid, sif4.busy, sif4.done, sif4.step_idx, sif4.a, sif4.b, sif4.c};
    checks++;
    if (obs !== 9'b001_000_000) begin
      errors++; $display("FAIL loop_done got=%b want=%b", obs, 9'b001_000_000);
    end
    @(negedge clk);
    obs = {sif4.valid, sif4.busy, sif4.done, sif4.step_idx, sif4.a, sif4.b, sif4.c};
    checks++;
    if (obs !== 9'b0) begin
      errors++; $display("FAIL loop_idle_after got=%b want=%b", obs, 9'b0);
    end
  endtask

  // Start pulsed during step 5 is ignored; a second sweep follows from IDLE.
  task automatic test_back_to_back();
    logic [8:0] obs, exp;
    for (int sw = 0; sw < 2; sw++) begin
      sif4.start = 1'b1;
      @(negedge clk);
      sif4.start = 1'b0;
      for (int k = 0; k < 32; k++) begin
        sif4.start = (sw == 0 && k == 20);
        exp = {3'b110, 3'(k / 4), exp_code(k / 4)};
        obs = {sif4.valid, sif4.busy, sif4.done, sif4.step_idx, sif4.a, sif4.b, sif4.c};
        checks++;
        if (obs !== exp) begin
          errors++; $display("FAIL b2b_sweep%0d_cycle%0d got=%b want=%b", sw, k, obs, exp);
        end
        @(negedge clk);
      end
      sif4.start = 1'b0;
      obs = {sif4.valid, sif4.busy, sif4.done, sif4.step_idx, sif4.a, sif4.b, sif4.c};
      checks++;
      if (obs !== 9'b001_000_000) begin
        errors++; $display("FAIL b2b_done%0d got=%b want=%b", sw, obs, 9'b001_000_000);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    logic [8:0] obs, exp;
    sif4.start = 1'b1;
    @(negedge clk);
    sif4.start = 1'b0;
    for (int k = 0; k < 14; k++) begin
      exp = {3'b110, 3'(k / 4), exp_code(k / 4)};
      obs = {sif4.valid, sif4.busy, sif4.done, sif4.step_idx, sif4.a, sif4.b, sif4.c};
      checks++;
      if (obs !== exp) begin
        errors++; $display("FAIL rstmid_cycle%0d got=%b want=%b", k, obs, exp);
      end
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    obs = {sif4.valid, sif4.busy, sif4.done, sif4.step_idx, sif4.a, sif4.b, sif4.c};
    checks++;
    if (obs !== 9'b0) begin
      errors++; $display("FAIL rstmid_abort got=%b want=%b", obs, 9'b0);
    end
    sif4.start = 1'b1;
    @(negedge clk);
    obs = {sif4.valid, sif4.busy, sif4.done, sif4.step_idx, sif4.a, sif4.b, sif4.c};
    checks++;
    if (obs !== 9'b0) begin
      errors++; $display("FAIL rst_start_same_cycle got=%b want=%b", obs, 9'b0);
    end
    rst = 1'b0;
    sif4.start = 1'b0;
    repeat (2) begin
      @(negedge clk);
      obs = {sif4.valid, sif4.busy, sif4.done, sif4.step_idx, sif4.a, sif4.b, sif4.c};
      checks++;
      if (obs !== 9'b0) begin
        errors++; $display("FAIL rstmid_no_done got=%b want=%b", obs, 9'b0);
      end
    end
  endtask

  task automatic test_dwell1();
    logic [8:0] obs, exp;
    logic [2:0] prev, cur;
    prev = 3'b000;
    sif1.start = 1'b1;
    @(negedge clk);
    sif1.start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      exp = {3'b110, 3'(k), exp_code(k)};
      obs = {sif1.valid, sif1.busy, sif1.done, sif1.step_idx, sif1.a, sif1.b, sif1.c};
      checks++;
      if (obs !== exp) begin
        errors++; $display("FAIL dwell1_cycle%0d got=%b want=%b", k, obs, exp);
      end
`ifdef SWEEP_GRAY_EN
      cur = {sif1.a, sif1.b, sif1.c};
      if (k > 0) begin
        checks++;
        if ($countones(cur ^ prev) != 1) begin
          errors++; $display("FAIL gray_hamming_step%0d got=%b->%b want=distance 1", k, prev, cur);
        end
      end
      if (k == 7) begin
        checks++;
        if ($countones(cur) != 1) begin
          errors++; $display("FAIL gray_hamming_wrap got=%b->000 want=distance 1", cur);
        end
      end
      prev = cur;
`else
      cur  = {sif1.a, sif1.b, sif1.c};
      prev = cur;
`endif
      @(negedge clk);
    end
    obs = {sif1.valid, sif1.busy, sif1.done, sif1.step_idx, sif1.a, sif1.b, sif1.c};
    checks++;
    if (obs !== 9'b001_000_000) begin
      errors++; $display("FAIL dwell1_done got=%b want=%b", obs, 9'b001_000_000);
    end
    @(negedge clk);
    obs = {sif1.valid, sif1.busy, sif1.done, sif1.step_idx, sif1.a, sif1.b, sif1.c};
    checks++;
    if (obs !== 9'b0) begin
      errors++; $display("FAIL dwell1_idle_after got=%b want=%b", obs, 9'b0);
    end
  endtask

  initial begin
    sif4.start = 1'b0; sif4.loop = 1'b0; sif4.hold = 1'b0;
    sif1.start = 1'b0; sif1.loop = 1'b0; sif1.hold = 1'b0;
    test_reset();
    test_full_sweep();
    test_hold();
    test_loop();
    test_back_to_back();
    test_reset_mid();
    test_dwell1();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/minterm_sweep_gen.md
# minterm_sweep_gen

Sequential stimulus source that sits directly upstream of the 3-to-8 decoder / function stage (`dec_func_dig`) and drives its `a`, `b`, `c` select inputs. On a start request it sweeps all eight minterms, holding each code for a programmable number of clock cycles. It flags valid codes and signals completion so downstream checkers can sample `d0..d7` and `f1..f3` at known points. It replaces hand-written per-step delays with a synthesizable, cycle-exact sequencer.

## Interface
Parameters:
- `DWELL`, 100, clock cycles each code is held; legal range 1..2^`CNT_W`.
- `CNT_W`, 7, width of the dwell counter.

Ports:
- `clk`  in  1  single system clock, rising-edge.
- `rst`  in  1  reset, synchronous and active-high.
- `start`  in  1  sweep request; sampled only in IDLE.
- `loop`  in  1  1 = wrap to the first code after the last instead of finishing; sampled at the wrap point.
- `hold`  in  1  1 = freeze dwell counter and code (pause).
- `a`  out  1  select MSB to decoder.
- `b`  out  1  select middle bit.
- `c`  out  1  select LSB.
- `step_idx`  out  3  binary index of the current step, 0..7.
- `valid`  out  1  high while `a,b,c` carry a sweep code.
- `busy`  out  1  high in RUN.
- `done`  out  1  one-cycle completion pulse.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - `a,b,c` = 000, `step_idx` = 0, `valid` = 0, `busy` = 0.
  - `start` = 1 moves the FSM to RUN.
- RUN:
  - `valid` = 1, `busy` = 1.
  - `{a,b,c}` = code(`step_idx`).
  - The dwell counter counts 0..`DWELL`-1.
  - When the counter reaches `DWELL`-1 with `hold` = 0:
    - counter clears;
    - if `step_idx` < 7, `step_idx` increments;
    - if `step_idx` = 7 and `loop` = 1, `step_idx` wraps to 0 and the FSM stays in RUN;
    - if `step_idx` = 7 and `loop` = 0, the FSM moves to DONE.
- DONE:
  - `done` = 1 for exactly one cycle.
  - `valid` = 0, `busy` = 0, `a,b,c` = 000.
  - The FSM returns to IDLE unconditionally.
- `hold` = 1 in RUN: counter, `step_idx`, and outputs are frozen, and `valid` stays 1. `hold` is ignored outside RUN.
- `start` in RUN or DONE is ignored; there is no queuing.
- All outputs are registered. There is no combinational path from any input to any output.

## Timing
- Reset: on a `clk` edge with `rst` = 1, the FSM goes to IDLE, `a,b,c` = 000, `step_idx` = 0, and `valid`/`busy`/`done` = 0. `rst` takes priority over `start`, `hold`, and `loop` in the same cycle.
- Reset mid-sweep aborts immediately with no `done` pulse.
- Start latency:
  - `start` sampled high at edge N gives `valid` = 1 and code 000 in the cycle after edge N.
  - The first code lasts exactly `DWELL` cycles, as does every later code when `hold` = 0.
- Full sweep with `hold` = 0 and `loop` = 0:
  - `valid` is high for 8×`DWELL` consecutive cycles.
  - `done` is high in the cycle immediately after the last code.
  - The earliest restart `start` is sampled in IDLE, 2 cycles after the last code ends.
- `DWELL` = 1: the code changes every cycle, and the counter stays at 0.
- `hold` asserted for H cycles extends the current code to `DWELL`+H cycles. `hold` coinciding with the terminal count blocks the step.
- `loop` dropped mid-sweep takes effect at the next 7→wrap point. The current sweep always completes.

## Configuration
- Macro: `SWEEP_GRAY_EN`.
- Defined: code(i) follows Gray order 000, 001, 011, 010, 110, 111, 101, 100. Exactly one of `a,b,c` toggles per step, including the 100→000 wrap.
- Undefined: code(i) = i in binary, 000 through 111.
- `step_idx` is binary 0..7 in both builds. Timing is identical in both builds.

## Test plan
- `DWELL`=4, `start` pulse → `valid` high for 32 cycles; `abc` = 000..111, each for 4 cycles; `done` pulse the next cycle; `busy` low after.
- `DWELL`=4, `hold` high for 3 cycles during step 2 → code 010 lasts 7 cycles; total `valid` = 35 cycles.
- `loop`=1 for 2 sweeps, then 0 → `step_idx` wraps 7→0 with no `valid` gap; a single `done` after the second 111 ends.
- `start` pulsed at step 5 of a sweep → no restart and no timing change; a later `start` in IDLE begins a new sweep at 000.
- `rst` asserted at step 3 → all outputs = 0/000 after the next edge and no `done`; `rst`+`start` in the same cycle → stays in IDLE.
- `SWEEP_GRAY_EN` defined, `DWELL`=1 → `abc` sequence 000, 001, 011, 010, 110, 111, 101, 100 on consecutive cycles; Hamming distance is 1 for every step.
